multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using ready/request handshakes to instruction and data memory.
- Drives datapath enables and mux selects per state, with the same select encodings as the single-cycle decoder.
- Adds bus-timeout and illegal/ECALL traps and an optional FENCE-as-NOP mode.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/opcode_classify.sv | 40 ++++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared opcodes, state/class enums and select encodings for the
//          RV32I control path.
// Rev    : 1.0
// ============================================================================
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_FENCE  = 7'd15;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_SYSTEM = 7'd115;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_LOAD    = 4'd1,
    CL_STORE   = 4'd2,
    CL_OPIMM   = 4'd3,
    CL_OP      = 4'd4,
    CL_LUI     = 4'd5,
    CL_AUIPC   = 4'd6,
    CL_BRANCH  = 4'd7,
    CL_JUMP    = 4'd8,
    CL_FENCE   = 4'd9,
    CL_SYSTEM  = 4'd10
  } op_class_t;

  localparam logic [1:0] ALUOP_FUNCT  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ADD    = 2'b10;

  localparam logic [1:0] SRC1_RS1  = 2'b00;
  localparam logic [1:0] SRC1_ZERO = 2'b01;
  localparam logic [1:0] SRC1_PC   = 2'b10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
  localparam logic [1:0] CAUSE_ECALL   = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

endpackage
`default_nettype wire

// File: rtl/opcode_classify.sv
`default_nettype none
// ============================================================================
// Module : opcode_classify
// Brief  : Combinational opcode to instruction-class decode with legal flag.
// Rev    : 1.0
// ============================================================================
module opcode_classify
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_FENCE = 1
) (
  input  logic [6:0] opcode_i,
  output op_class_t  class_o,
  output logic       legal_o
);

  always_comb begin
    class_o = CL_ILLEGAL;
    case (opcode_i)
      OPC_LOAD:   class_o = CL_LOAD;
      OPC_STORE:  class_o = CL_STORE;
      OPC_OPIMM:  class_o = CL_OPIMM;
      OPC_OP:     class_o = CL_OP;
      OPC_LUI:    class_o = CL_LUI;
      OPC_AUIPC:  class_o = CL_AUIPC;
      OPC_BRANCH: class_o = CL_BRANCH;
      OPC_JAL:    class_o = CL_JUMP;
      OPC_JALR:   class_o = CL_JUMP;
      OPC_SYSTEM: class_o = CL_SYSTEM;
      OPC_FENCE: begin
        if (SUPPORT_FENCE != 0) class_o = CL_FENCE;
      end
      default:    class_o = CL_ILLEGAL;
    endcase
    // SYSTEM is recognised only so the caller can report it as ECALL/EBREAK
    legal_o = (class_o != CL_ILLEGAL) && (class_o != CL_SYSTEM);
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control
// Brief  : Multi-cycle RV32I control FSM with memory handshakes and traps.
// Rev    : 1.0
// ============================================================================
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT       = 16,
  parameter int SUPPORT_FENCE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opCode,
  input  logic       imemReady,
  input  logic       dmemReady,
  input  logic       branchTaken,
  output logic       imemReq,
  output logic       dmemReq,
  output logic       irWe,
  output logic       pcWe,
  output logic       branch,
  output logic       forceJump,
  output logic       RAMwe,
  output logic       Regwe,
  output logic       ALUSrc2,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrc1,
  output logic [1:0] RegWriteSrc,
  output logic       instrDone,
  output logic       trap,
  output logic [1:0] trapCause
);

  localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  op_class_t       class_q, class_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;

  op_class_t       dec_class;
  logic            dec_legal;
  logic            wait_expired;

  opcode_classify #(
    .SUPPORT_FENCE (SUPPORT_FENCE)
  ) u_classify (
    .opcode_i (opCode),
    .class_o  (dec_class),
    .legal_o  (dec_legal)
  );

  assign wait_expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign trapCause    = (state_q == S_TRAP) ? cause_q : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      class_q <= CL_ILLEGAL;
      cnt_q   <= '0;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    cnt_d       = '0;
    cause_d     = cause_q;
    imemReq     = 1'b0;
    dmemReq     = 1'b0;
    irWe        = 1'b0;
    pcWe        = 1'b0;
    branch      = 1'b0;
    forceJump   = 1'b0;
    RAMwe       = 1'b0;
    Regwe       = 1'b0;
    ALUSrc2     = 1'b0;
    ALUOp       = ALUOP_FUNCT;
    ALUSrc1     = SRC1_RS1;
    RegWriteSrc = WB_MEM;
    instrDone   = 1'b0;
    trap        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // A ready in the final allowed cycle takes priority over the timeout
      S_FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          irWe    = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        class_d = dec_class;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = (dec_class == CL_SYSTEM) ? CAUSE_ECALL : CAUSE_ILLEGAL;
        end
      end

      S_EXEC: begin
        case (class_q)
          CL_LOAD, CL_STORE: begin
            ALUOp   = ALUOP_ADD;
            state_d = S_MEM;
          end
          CL_OPIMM: state_d = S_WB;
          CL_OP: begin
            ALUSrc2 = 1'b1;
            state_d = S_WB;
          end
          CL_LUI: begin
            ALUOp   = ALUOP_ADD;
            ALUSrc1 = SRC1_ZERO;
            state_d = S_WB;
          end
          CL_AUIPC: begin
            ALUOp   = ALUOP_ADD;
            ALUSrc1 = SRC1_PC;
            state_d = S_WB;
          end
          CL_BRANCH: begin
            ALUOp     = ALUOP_BRANCH;
            ALUSrc2   = 1'b1;
            branch    = 1'b1;
            pcWe      = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
          CL_JUMP: begin
            ALUOp   = ALUOP_ADD;
            state_d = S_WB;
          end
          CL_FENCE: begin
            pcWe      = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        ALUOp   = ALUOP_ADD;
        dmemReq = 1'b1;
        RAMwe   = (class_q == CL_STORE);
        if (dmemReady) begin
          if (class_q == CL_STORE) begin
            pcWe      = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        Regwe     = 1'b1;
        pcWe      = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
        case (class_q)
          CL_LOAD: RegWriteSrc = WB_MEM;
          CL_JUMP: begin
            RegWriteSrc = WB_PC4;
            forceJump   = 1'b1;
          end
          default: RegWriteSrc = WB_ALU;
        endcase
      end

      S_TRAP: trap = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed-vector bench; three DUT variants (timeouts 16/4/0).
// Rev    : 1.0
// ============================================================================
module tb_multicycle_control;

  typedef struct packed {
    logic       imemReq;
    logic       dmemReq;
    logic       irWe;
    logic       pcWe;
    logic       branch;
    logic       forceJump;
    logic       RAMwe;
    logic       Regwe;
    logic       ALUSrc2;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrc1;
    logic [1:0] RegWriteSrc;
    logic       instrDone;
    logic       trap;
    logic [1:0] trapCause;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic       imr;
    logic       dmr;
    logic       bt;
    logic [6:0] op;
    bit         chk;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_v, imr_v, dmr_v, bt_v;
  logic [2:0][6:0] op_v;
  outs_t [2:0]     out_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       imemReq, dmemReq, irWe, pcWe, branch, forceJump, RAMwe, Regwe, ALUSrc2;
    logic       instrDone, trap;
    logic [1:0] ALUOp, ALUSrc1, RegWriteSrc, trapCause;

    multicycle_control #(
      .TIMEOUT       (g == 0 ? 16 : (g == 1 ? 4 : 0)),
      .SUPPORT_FENCE (g == 2 ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_v[g]),
      .opCode      (op_v[g]),
      .imemReady   (imr_v[g]),
      .dmemReady   (dmr_v[g]),
      .branchTaken (bt_v[g]),
      .imemReq     (imemReq),
      .dmemReq     (dmemReq),
      .irWe        (irWe),
      .pcWe        (pcWe),
      .branch      (branch),
      .forceJump   (forceJump),
      .RAMwe       (RAMwe),
      .Regwe       (Regwe),
      .ALUSrc2     (ALUSrc2),
      .ALUOp       (ALUOp),
      .ALUSrc1     (ALUSrc1),
      .RegWriteSrc (RegWriteSrc),
      .instrDone   (instrDone),
      .trap        (trap),
      .trapCause   (trapCause)
    );

    assign out_v[g] = {imemReq, dmemReq, irWe, pcWe, branch, forceJump, RAMwe, Regwe,
                       ALUSrc2, ALUOp, ALUSrc1, RegWriteSrc, instrDone, trap, trapCause};
  end

  vec_t tq[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   tag        = 0;
  int   to_cur     = 16;
  bit   fence_cur  = 1'b1;
  int   da, ta;

  task automatic push(input logic rst_n, input logic imr, input logic dmr, input logic bt,
                      input logic [6:0] op, input bit chk, input outs_t e);
    vec_t v;
    v.rst_n = rst_n; v.imr = imr; v.dmr = dmr; v.bt = bt; v.op = op; v.chk = chk; v.exp = e;
    tq.push_back(v);
  endtask

  // Instruction kinds as the architecture describes them
  function automatic string kind(input logic [6:0] op);
    case (op)
      7'd3:          return "load";
      7'd35:         return "store";
      7'd19:         return "opimm";
      7'd51:         return "op";
      7'd55:         return "lui";
      7'd23:         return "auipc";
      7'd99:         return "branch";
      7'd103, 7'd111: return "jump";
      7'd15:         return fence_cur ? "fence" : "illegal";
      7'd115:        return "ecall";
      default:       return "illegal";
    endcase
  endfunction

  task automatic push_trap(input logic [6:0] op, input logic [1:0] cause, input int n);
    outs_t e;
    e = '0; e.trap = 1'b1; e.trapCause = cause;
    for (int i = 0; i < n; i++) push(1, 0, 0, 0, op, 1, e);
  endtask

  task automatic push_reset_from(input outs_t cur);
    outs_t e;
    push(0, 0, 0, 0, 7'd0, 1, cur);
    e = '0;
    push(1, 0, 0, 0, 7'd0, 1, e);
  endtask

  task automatic begin_test(input int t, input int to, input bit fe);
    tag = t; to_cur = to; fence_cur = fe;
    push(0, 0, 0, 0, 7'd0, 0, '0);
    push(1, 0, 0, 0, 7'd0, 1, '0);
  endtask

  // Expected trace for one instruction: fw/mw are cycles before ready arrives
  task automatic push_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                            input bit rst_in_mem, input int trap_n);
    outs_t e;
    string k;
    for (int c = 0; ; c++) begin
      e = '0; e.imemReq = 1'b1;
      if (c >= fw) begin
        e.irWe = 1'b1;
        push(1, 1, 0, 0, op, 1, e);
        break;
      end
      push(1, 0, 0, 0, op, 1, e);
      if (to_cur != 0 && c == to_cur - 1) begin
        push_trap(op, 2'b10, trap_n);
        return;
      end
    end
    push(1, 0, 0, 0, op, 1, '0);
    k = kind(op);
    if (k == "ecall")   begin push_trap(op, 2'b01, trap_n); return; end
    if (k == "illegal") begin push_trap(op, 2'b00, trap_n); return; end
    e = '0;
    if (k == "load" || k == "store" || k == "jump") e.ALUOp = 2'b10;
    if (k == "op") e.ALUSrc2 = 1'b1;
    if (k == "lui")   begin e.ALUOp = 2'b10; e.ALUSrc1 = 2'b01; end
    if (k == "auipc") begin e.ALUOp = 2'b10; e.ALUSrc1 = 2'b10; end
    if (k == "branch") begin
      e.ALUOp = 2'b01; e.ALUSrc2 = 1'b1; e.branch = 1'b1; e.pcWe = 1'b1; e.instrDone = 1'b1;
    end
    if (k == "fence") begin e.pcWe = 1'b1; e.instrDone = 1'b1; end
    push(1, 0, 0, bt, op, 1, e);
    if (k == "branch" || k == "fence") return;
    if (k == "load" || k == "store") begin
      for (int c = 0; ; c++) begin
        e = '0; e.ALUOp = 2'b10; e.dmemReq = 1'b1; e.RAMwe = (k == "store");
        if (rst_in_mem) begin
          push(0, 0, 0, 0, op, 1, e);
          push(1, 0, 0, 0, op, 1, '0);
          return;
        end
        if (c >= mw) begin
          if (k == "store") begin e.pcWe = 1'b1; e.instrDone = 1'b1; end
          push(1, 0, 1, 0, op, 1, e);
          if (k == "store") return;
          break;
        end
        push(1, 0, 0, 0, op, 1, e);
        if (to_cur != 0 && c == to_cur - 1) begin
          push_trap(op, 2'b10, trap_n);
          return;
        end
      end
    end
    e = '0; e.Regwe = 1'b1; e.pcWe = 1'b1; e.instrDone = 1'b1;
    e.RegWriteSrc = (k == "load") ? 2'b00 : ((k == "jump") ? 2'b10 : 2'b01);
    e.forceJump = (k == "jump");
    push(1, 0, 0, 0, op, 1, e);
  endtask

  // Apply queued vectors to DUT d and compare every flagged cycle
  task automatic run(input int d, output int done_at, output int trap_at);
    done_at = -1; trap_at = -1;
    foreach (tq[i]) begin
      @(posedge clk); #1;
      rst_v[d] = tq[i].rst_n; imr_v[d] = tq[i].imr; dmr_v[d] = tq[i].dmr;
      bt_v[d] = tq[i].bt; op_v[d] = tq[i].op;
      @(negedge clk);
      if (tq[i].chk) begin
        vectors++;
        if (out_v[d] !== tq[i].exp) begin
          miscompares++;
          $display("FAIL test%0d cycle%0d outputs: got %b required %b", tag, i, out_v[d], tq[i].exp);
        end
      end
      if (done_at < 0 && out_v[d].instrDone === 1'b1) done_at = i - 1;
      if (trap_at < 0 && out_v[d].trap === 1'b1) trap_at = i - 1;
    end
    tq.delete();
  endtask

  task automatic lit(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL test%0d %s: got %0d required %0d", tag, name, got, want);
    end
  endtask

  outs_t trap01;

  initial begin
    rst_v = '0; imr_v = '0; dmr_v = '0; bt_v = '0; op_v = '0;

    begin_test(1, 16, 1);
    push_instr(7'd19, 0, 0, 0, 0, 0);
    lit("addi_trace_len", tq.size(), 6);
    lit("addi_wb_vector", int'(tq[5].exp), int'(19'b000100010_00_00_01_1_0_00));
    run(0, da, ta);
    lit("addi_retire_cycle", da, 4);

    begin_test(2, 16, 1);
    push_instr(7'd3, 0, 3, 0, 0, 0);
    run(0, da, ta);
    lit("lw_retire_cycle", da, 8);

    begin_test(3, 16, 1);
    push_instr(7'd99, 0, 0, 1, 0, 0);
    push_instr(7'd19, 0, 0, 0, 0, 0);
    run(0, da, ta);
    lit("beq_retire_cycle", da, 3);

    begin_test(4, 16, 1);
    push_instr(7'd51, 1, 0, 0, 0, 0);
    push_instr(7'd55, 0, 0, 0, 0, 0);
    push_instr(7'd23, 2, 0, 0, 0, 0);
    push_instr(7'd111, 0, 0, 0, 0, 0);
    push_instr(7'd103, 1, 0, 0, 0, 0);
    push_instr(7'd35, 0, 2, 0, 0, 0);
    push_instr(7'd15, 0, 0, 0, 0, 0);
    push_instr(7'd19, 15, 0, 0, 0, 0);
    push_instr(7'd3, 0, 15, 0, 0, 0);
    push_instr(7'd115, 0, 0, 0, 0, 3);
    trap01 = '0; trap01.trap = 1'b1; trap01.trapCause = 2'b01;
    push_reset_from(trap01);
    push_instr(7'd19, 0, 0, 0, 0, 0);
    run(0, da, ta);

    begin_test(5, 16, 1);
    push_instr(7'd127, 0, 0, 0, 0, 20);
    trap01.trapCause = 2'b00;
    push_reset_from(trap01);
    push_instr(7'd19, 1, 0, 0, 0, 0);
    run(0, da, ta);
    lit("illegal_trap_cycle", ta, 3);

    begin_test(6, 16, 1);
    push_instr(7'd35, 0, 5, 0, 1, 0);
    push_instr(7'd35, 0, 1, 0, 0, 0);
    run(0, da, ta);

    begin_test(7, 4, 1);
    push_instr(7'd19, 1000, 0, 0, 0, 3);
    run(1, da, ta);
    lit("fetch_timeout_cycle", ta, 5);
    lit("fetch_timeout_cause", int'(out_v[1].trapCause), 2);

    begin_test(8, 4, 1);
    push_instr(7'd19, 3, 0, 0, 0, 0);
    push_instr(7'd3, 0, 3, 0, 0, 0);
    push_instr(7'd35, 0, 1000, 0, 0, 2);
    run(1, da, ta);
    lit("ready_last_cycle_retire", da, 7);

    begin_test(9, 0, 0);
    push_instr(7'd19, 40, 0, 0, 0, 0);
    push_instr(7'd15, 0, 0, 0, 0, 4);
    run(2, da, ta);
    lit("nofence_trap_flag", int'(out_v[2].trap), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
